alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_flag_class.sv | 33 +++
 rtl/alu_writeback.sv | 97 +++++++++
 tb/tb_alu_writeback.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback slice: opcode/extension encodings,
// PSR flag bit positions and the flag-update class.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int FLAG_W = 5;

    // PSR layout {C,L,F,Z,N}
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    localparam logic [3:0] OP_REG   = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_ADDUI = 4'h6;
    localparam logic [3:0] OP_ADDCI = 4'h7;
    localparam logic [3:0] OP_SUBI  = 4'h9;
    localparam logic [3:0] OP_MISC  = 4'hA;
    localparam logic [3:0] OP_CMPI  = 4'hB;

    localparam logic [3:0] EXT_CMPM = 4'h2;
    localparam logic [3:0] EXT_ADD  = 4'h5;
    localparam logic [3:0] EXT_ADDU = 4'h6;
    localparam logic [3:0] EXT_ADDC = 4'h7;
    localparam logic [3:0] EXT_SUB  = 4'h9;
    localparam logic [3:0] EXT_CMP  = 4'hB;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        ARITH   = 2'd1,
        COMPARE = 2'd2
    } flag_class_e;

endpackage

// File: rtl/alu_flag_class.sv
// Combinational decode of {opcode,opext} into the PSR flag-update class.
module alu_flag_class
    import alu_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [3:0]  opext,
    output flag_class_e cls
);

    always_comb begin
        cls = NONE;
        case (opcode)
            OP_REG: begin
                case (opext)
                    EXT_ADD, EXT_ADDU, EXT_ADDC, EXT_SUB: cls = ARITH;
                    EXT_CMP:                              cls = COMPARE;
                    default:                              cls = NONE;
                endcase
            end
            OP_ADDI, OP_ADDUI, OP_ADDCI, OP_SUBI: cls = ARITH;
            OP_CMPI: cls = COMPARE;
            OP_MISC: begin
                case (opext)
                    EXT_ADD, EXT_ADDU: cls = ARITH;
                    EXT_CMPM:          cls = COMPARE;
                    default:           cls = NONE;
                endcase
            end
            default: cls = NONE;
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// One-entry writeback stage between the ALU and the register file; also owns
// the PSR, whose flags are updated when a result is accepted rather than drained.
module alu_writeback
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_result,
    input  logic [4:0]  in_clfzn,
    input  logic [3:0]  in_opcode,
    input  logic [3:0]  in_opext,
    input  logic [3:0]  in_rdest,
    input  logic        in_we,
    input  logic        psr_we,
    input  logic [4:0]  psr_wdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_we,
    output logic [3:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic [4:0]  psr,
    output logic        carry_in,
    output logic [15:0] retire_count
);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e      state;
    flag_class_e cls;
    logic        accept;
    logic        drain;
    logic [4:0]  psr_next;

    alu_flag_class u_flag_class (
        .opcode (in_opcode),
        .opext  (in_opext),
        .cls    (cls)
    );

    // A draining entry frees the slot in the same cycle, so back-to-back results flow without a bubble.
    assign in_ready = (state == EMPTY) || wb_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = wb_valid && wb_ready;
    assign wb_valid = (state == FULL);
    assign carry_in = psr[FLAG_C];

    always_comb begin
        psr_next = psr;
        if (psr_we) begin
            psr_next = psr_wdata;
        end else if (accept) begin
            case (cls)
                ARITH: begin
                    psr_next[FLAG_C] = in_clfzn[FLAG_C];
                    psr_next[FLAG_F] = in_clfzn[FLAG_F];
                end
                COMPARE: begin
                    psr_next[FLAG_L] = in_clfzn[FLAG_L];
                    psr_next[FLAG_Z] = in_clfzn[FLAG_Z];
                    psr_next[FLAG_N] = in_clfzn[FLAG_N];
                end
                default: psr_next = psr;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= EMPTY;
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            if (accept) begin
                state   <= FULL;
                wb_data <= in_result;
                wb_addr <= in_rdest;
                wb_we   <= (cls == COMPARE) ? 1'b0 : in_we;
            end else if (drain) begin
                state <= EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psr          <= '0;
            retire_count <= '0;
        end else begin
            psr <= psr_next;
            if (drain) retire_count <= retire_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus random traffic
// compared against a transaction-level model of the stage and PSR.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [4:0]  in_clfzn;
    logic [3:0]  in_opcode;
    logic [3:0]  in_opext;
    logic [3:0]  in_rdest;
    logic        in_we;
    logic        psr_we;
    logic [4:0]  psr_wdata;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [4:0]  psr;
    logic        carry_in;
    logic [15:0] retire_count;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic        m_full;
    logic [15:0] m_data;
    logic [3:0]  m_addr;
    logic        m_we;
    logic [4:0]  m_psr;
    logic [15:0] m_cnt;

    alu_writeback dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_clfzn     (in_clfzn),
        .in_opcode    (in_opcode),
        .in_opext     (in_opext),
        .in_rdest     (in_rdest),
        .in_we        (in_we),
        .psr_we       (psr_we),
        .psr_wdata    (psr_wdata),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .psr          (psr),
        .carry_in     (carry_in),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    // 1 = arithmetic (C,F), 2 = compare (L,Z,N), 0 = no flag update
    function automatic int flag_kind(input logic [3:0] op, input logic [3:0] ex);
        logic [7:0] k;
        k = {op, ex};
        if (k inside {8'h05, 8'h06, 8'h07, 8'h09, 8'hA5, 8'hA6} || op inside {4'h5, 4'h6, 4'h7, 4'h9})
            return 1;
        if (k inside {8'h0B, 8'hA2} || op == 4'hB)
            return 2;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] res, input logic [4:0] f,
                         input logic [3:0] op, input logic [3:0] ex, input logic [3:0] rd,
                         input logic we, input logic rdy, input logic pwe, input logic [4:0] pwd);
        in_valid = v; in_result = res; in_clfzn = f; in_opcode = op; in_opext = ex;
        in_rdest = rd; in_we = we; wb_ready = rdy; psr_we = pwe; psr_wdata = pwd;
    endtask

    task automatic model_reset();
        m_full = 1'b0; m_data = '0; m_addr = '0; m_we = 1'b0; m_psr = '0; m_cnt = '0;
    endtask

    task automatic check_state();
        chk("wb_valid", 16'(wb_valid), 16'(m_full));
        chk("psr", 16'(psr), 16'(m_psr));
        chk("carry_in", 16'(carry_in), 16'(m_psr[4]));
        chk("retire_count", retire_count, m_cnt);
        if (m_full) begin
            chk("wb_data", wb_data, m_data);
            chk("wb_addr", 16'(wb_addr), 16'(m_addr));
            chk("wb_we", 16'(wb_we), 16'(m_we));
        end
    endtask

    // One clock: check in_ready, advance the model on the current inputs, then check outputs.
    task automatic step();
        logic rdy, acc, drn;
        int   kind;
        #1;
        rdy  = !m_full || wb_ready;
        acc  = in_valid && rdy;
        drn  = m_full && wb_ready;
        kind = flag_kind(in_opcode, in_opext);
        chk("in_ready", 16'(in_ready), 16'(rdy));
        if (psr_we)
            m_psr = psr_wdata;
        else if (acc && kind == 1)
            m_psr = {in_clfzn[4], m_psr[3], in_clfzn[2], m_psr[1:0]};
        else if (acc && kind == 2)
            m_psr = {m_psr[4], in_clfzn[3], m_psr[2], in_clfzn[1:0]};
        if (drn) m_cnt = m_cnt + 16'd1;
        if (acc) begin
            m_full = 1'b1; m_data = in_result; m_addr = in_rdest;
            m_we = (kind == 2) ? 1'b0 : in_we;
        end else if (drn) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #2;
        chk("rst_wb_valid", 16'(wb_valid), 16'h0);
        chk("rst_psr", 16'(psr), 16'h0);
        chk("rst_count", retire_count, 16'h0);
        chk("rst_wb_data", wb_data, 16'h0);
        chk("rst_wb_addr", 16'(wb_addr), 16'h0);
        chk("rst_wb_we", 16'(wb_we), 16'h0);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 16'(in_ready), 16'h1);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 16'h0, 5'h0, 4'h1, 4'h0, 4'h0, 0, 0, 0, 5'h0);
        #3;
        do_reset();

        // ADD with carry and F set
        drive(1, 16'h1234, 5'b10100, 4'h0, 4'h5, 4'd3, 1, 1, 0, 5'h0);
        step();
        chk("add_wb_data", wb_data, 16'h1234);
        chk("add_wb_addr", 16'(wb_addr), 16'd3);
        chk("add_psr", 16'(psr), 16'b10100);
        chk("add_carry_in", 16'(carry_in), 16'h1);

        // CMP updates L,Z,N only and suppresses the write
        drive(1, 16'h5555, 5'b01010, 4'h0, 4'hB, 4'd4, 1, 1, 0, 5'h0);
        step();
        chk("add_retired", retire_count, 16'd1);
        chk("cmp_wb_we", 16'(wb_we), 16'h0);
        chk("cmp_psr", 16'(psr), 16'b11110);

        // stall with 0xBEEF pending
        drive(1, 16'hBEEF, 5'b00000, 4'h1, 4'h0, 4'd7, 1, 1, 0, 5'h0);
        step();
        drive(1, 16'h0001, 5'b00000, 4'h1, 4'h0, 4'd8, 1, 0, 0, 5'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_in_ready", 16'(in_ready), 16'h0);
            chk("stall_wb_data", wb_data, 16'hBEEF);
        end
        wb_ready = 1'b1;
        step();
        chk("unstall_wb_data", wb_data, 16'h0001);

        // software PSR load beats the ADDU flag update
        drive(1, 16'h0042, 5'b10100, 4'h0, 4'h6, 4'd2, 1, 1, 1, 5'b00001);
        step();
        chk("psr_we_wins", 16'(psr), 16'b00001);

        // asynchronous reset in the middle of a stall
        drive(1, 16'hCAFE, 5'b10100, 4'h5, 4'h0, 4'd9, 1, 1, 0, 5'h0);
        step();
        drive(1, 16'h7777, 5'b00000, 4'h1, 4'h0, 4'd1, 1, 0, 0, 5'h0);
        step();
        in_valid = 1'b0;
        do_reset();

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] op, ex;
            op = 4'($urandom_range(0, 15));
            ex = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15))
                 : ((($urandom_range(0, 1)) == 1) ? 4'h5 : 4'hB);
            if ($urandom_range(0, 3) == 0) op = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'hA;
            drive($urandom_range(0, 3) != 0, 16'($urandom), 5'($urandom), op, ex,
                  4'($urandom), 1'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0, 5'($urandom));
            step();
        end

        // retire counter wrap: 65535 drains then one more
        drive(0, 16'h0, 5'h0, 4'h1, 4'h0, 4'h0, 0, 1, 0, 5'h0);
        do_reset();
        drive(1, 16'h0, 5'h0, 4'h1, 4'h0, 4'h0, 1, 1, 0, 5'h0);
        for (int i = 0; i < 65536; i++) begin
            in_result = 16'(i);
            step();
        end
        chk("count_ffff", retire_count, 16'hFFFF);
        step();
        chk("count_wrap", retire_count, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
